// File: rtl/inst_rom_loader_if.sv
// Load-stream and fetch-port bundle for the instruction ROM loader.
// master: the side that drives the load stream and fetch requests and sees the status flags.
// slave: the loader itself.
// Ports: load_start_i/load_byte_i/load_valid_i/load_ready_o form the load stream;
//        rom_ce_i/rom_addr_i/rom_data_o form the core fetch port;
//        cpu_rst_o/load_done_o/load_err_o are the loader status outputs.
interface inst_rom_loader_if;
    logic        load_start_i;
    logic [7:0]  load_byte_i;
    logic        load_valid_i;
    logic        load_ready_o;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        cpu_rst_o;
    logic        load_done_o;
    logic        load_err_o;

    modport master (
        output load_start_i, load_byte_i, load_valid_i, rom_ce_i, rom_addr_i,
        input  load_ready_o, rom_data_o, cpu_rst_o, load_done_o, load_err_o
    );

    modport slave (
        input  load_start_i, load_byte_i, load_valid_i, rom_ce_i, rom_addr_i,
        output load_ready_o, rom_data_o, cpu_rst_o, load_done_o, load_err_o
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction RAM filled from a byte-serial header+image stream, read combinationally by the core.
// Latency: fetch read is zero-cycle; status flags are registered and update on the accepting edge.
// Backpressure: load_ready_o is high only in HDR_HI/HDR_LO/DATA; IDLE/DONE/ERR accept nothing.
// Ports: clk, rst (async active-high), bus (inst_rom_loader_if.slave) carrying the load
//        stream, the fetch port and the cpu_rst/done/err status outputs.
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Header limit compared in 17 bits so that N == 2^16 can never alias.
    localparam logic [16:0] DEPTH17   = 17'(DEPTH);
    localparam logic [ADDR_W:0] WA_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t         state, state_n;
    logic [15:0]    n_words, n_words_n;
    // One bit wider than the RAM index so a full 2^ADDR_W image counts to its end.
    logic [ADDR_W:0] waddr, waddr_n;
    logic [1:0]     bidx, bidx_n;
    // Only the first three bytes of a word need holding; the fourth goes straight to RAM.
    logic [23:0]    asm_q, asm_n;
    logic           cpu_rst_q, cpu_rst_n;
    logic           done_q, done_n;
    logic           err_q, err_n;

    logic           mem_we;
    logic [31:0]    mem_wdat;
    logic [31:0]    mem [0:DEPTH-1];

    logic           accept;
    logic [15:0]    n_lo;
    logic [16:0]    wcount_next;
    logic           unused_addr_bits;

    assign bus.load_ready_o = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_DATA);
    assign accept           = bus.load_valid_i && bus.load_ready_o && !bus.load_start_i;
    assign n_lo             = {n_words[15:8], bus.load_byte_i};
    assign wcount_next      = 17'(waddr) + 17'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            n_words   <= '0;
            waddr     <= '0;
            bidx      <= '0;
            asm_q     <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            n_words   <= n_words_n;
            waddr     <= waddr_n;
            bidx      <= bidx_n;
            asm_q     <= asm_n;
            cpu_rst_q <= cpu_rst_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        n_words_n = n_words;
        waddr_n   = waddr;
        bidx_n    = bidx;
        asm_n     = asm_q;
        cpu_rst_n = cpu_rst_q;
        done_n    = done_q;
        err_n     = err_q;
        mem_we    = 1'b0;
        mem_wdat  = {asm_q, bus.load_byte_i};

        if (bus.load_start_i) begin
            // Restart wins over everything: any half-built word and same-cycle byte are lost.
            state_n   = S_HDR_HI;
            cpu_rst_n = 1'b1;
            done_n    = 1'b0;
            err_n     = 1'b0;
            waddr_n   = '0;
            bidx_n    = '0;
        end else begin
            case (state)
                S_HDR_HI: begin
                    if (accept) begin
                        n_words_n[15:8] = bus.load_byte_i;
                        state_n         = S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (accept) begin
                        n_words_n = n_lo;
                        if ((n_lo == 16'd0) || ({1'b0, n_lo} > DEPTH17)) begin
                            state_n   = S_ERR;
                            err_n     = 1'b1;
                            cpu_rst_n = 1'b1;
                        end else begin
                            state_n = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (bidx == 2'd3) begin
                            mem_we  = 1'b1;
                            waddr_n = waddr + WA_ONE;
                            bidx_n  = 2'd0;
                            if (wcount_next == {1'b0, n_words}) begin
                                state_n   = S_DONE;
                                done_n    = 1'b1;
                                cpu_rst_n = 1'b0;
                            end
                        end else begin
                            bidx_n = bidx + 2'd1;
                            asm_n  = {asm_q[15:0], bus.load_byte_i};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr[ADDR_W-1:0]] <= mem_wdat;
        end
    end

    // Byte offset within the word is irrelevant to a word-wide fetch.
    assign unused_addr_bits = ^bus.rom_addr_i[1:0];

    always_comb begin
        bus.rom_data_o = 32'd0;
        if (bus.rom_ce_i && (bus.rom_addr_i[31:ADDR_W+2] == '0)) begin
            bus.rom_data_o = mem[bus.rom_addr_i[ADDR_W+1:2]];
        end
    end

    assign bus.cpu_rst_o   = cpu_rst_q;
    assign bus.load_done_o = done_q;
    assign bus.load_err_o  = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: header, image load, restart, errors, async reset, fetch.
// Inputs are driven 1ns after the rising edge and outputs sampled just before the next change.
module tb_inst_rom_loader;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    inst_rom_loader_if bus ();

    inst_rom_loader #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_start_i = 1'b1;
        tick();
        bus.load_start_i = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        bus.load_valid_i = 1'b1;
        bus.load_byte_i  = b;
        tick();
        bus.load_valid_i = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w);
        put_byte(w[31:24]);
        put_byte(w[23:16]);
        put_byte(w[15:8]);
        put_byte(w[7:0]);
    endtask

    task automatic idle_gap(input int cycles);
        bus.load_valid_i = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            bus.load_byte_i = 8'($urandom);
            tick();
        end
    endtask

    task automatic rd(input logic ce, input logic [31:0] addr, output logic [31:0] data);
        bus.rom_ce_i   = ce;
        bus.rom_addr_i = addr;
        #1;
        data = bus.rom_data_o;
    endtask

    logic [7:0]  img [0:9];
    logic [31:0] d;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        img[0] = 8'h00; img[1] = 8'h02; img[2] = 8'h34; img[3] = 8'h01; img[4] = 8'h11;
        img[5] = 8'h00; img[6] = 8'h34; img[7] = 8'h02; img[8] = 8'h00; img[9] = 8'h20;

        rst              = 1'b1;
        bus.load_start_i = 1'b0;
        bus.load_byte_i  = 8'h00;
        bus.load_valid_i = 1'b0;
        bus.rom_ce_i     = 1'b0;
        bus.rom_addr_i   = 32'h0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // 1. Reset / idle
        chk("rst_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
        chk("rst_ready",   32'(bus.load_ready_o), 32'd0);
        chk("rst_done",    32'(bus.load_done_o), 32'd0);
        chk("rst_err",     32'(bus.load_err_o), 32'd0);
        rd(1'b0, 32'h0, d);
        chk("rst_rd_ce0", d, 32'h0);
        // Bytes offered in IDLE must be ignored.
        put_byte(8'h00);
        chk("idle_ready", 32'(bus.load_ready_o), 32'd0);

        // 2. Normal back-to-back load
        start_load();
        chk("hdr_ready", 32'(bus.load_ready_o), 32'd1);
        for (int i = 0; i < 9; i++) put_byte(img[i]);
        chk("pre_last_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
        chk("pre_last_done",    32'(bus.load_done_o), 32'd0);
        put_byte(img[9]);
        chk("norm_done",    32'(bus.load_done_o), 32'd1);
        chk("norm_cpu_rst", 32'(bus.cpu_rst_o), 32'd0);
        chk("norm_ready",   32'(bus.load_ready_o), 32'd0);
        chk("norm_err",     32'(bus.load_err_o), 32'd0);
        rd(1'b1, 32'h0, d); chk("norm_rd0", d, 32'h34011100);
        rd(1'b1, 32'h4, d); chk("norm_rd4", d, 32'h34020020);
        rd(1'b1, 32'h6, d); chk("norm_rd6", d, 32'h34020020);
        rd(1'b0, 32'h0, d); chk("norm_rd_ce0", d, 32'h0);
        rd(1'b1, 32'h00001000, d); chk("oor_rd", d, 32'h0);
        rd(1'b0, 32'h0, d);

        // 4. Header errors
        start_load();
        put_byte(8'h00);
        put_byte(8'h00);
        chk("n0_err",     32'(bus.load_err_o), 32'd1);
        chk("n0_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
        chk("n0_ready",   32'(bus.load_ready_o), 32'd0);
        chk("n0_done",    32'(bus.load_done_o), 32'd0);
        start_load();
        chk("restart_err_clr", 32'(bus.load_err_o), 32'd0);
        put_byte(8'h04);
        put_byte(8'h01);
        chk("n401_err", 32'(bus.load_err_o), 32'd1);

        // Full-depth image: word i = 0xC0DE0000 + i.
        start_load();
        put_byte(8'h04);
        put_byte(8'h00);
        chk("n400_noerr", 32'(bus.load_err_o), 32'd0);
        for (int i = 0; i < 1023; i++) put_word(32'hC0DE0000 + 32'(i));
        chk("n400_pre_done", 32'(bus.load_done_o), 32'd0);
        put_word(32'hC0DE03FF);
        chk("n400_done",    32'(bus.load_done_o), 32'd1);
        chk("n400_cpu_rst", 32'(bus.cpu_rst_o), 32'd0);
        rd(1'b1, 32'hFFC, d); chk("n400_rd_last", d, 32'hC0DE03FF);
        rd(1'b1, 32'h0,   d); chk("n400_rd0",     d, 32'hC0DE0000);
        rd(1'b1, 32'h800, d); chk("n400_rd200",   d, 32'hC0DE0200);
        rd(1'b0, 32'h0, d);

        // 3. Gapped stream of the same two-word image over the full-depth contents
        start_load();
        for (int i = 0; i < 10; i++) begin
            idle_gap($urandom_range(0, 3));
            if (i == 9) begin
                chk("gap_pre_done", 32'(bus.load_done_o), 32'd0);
                chk("gap_pre_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
            end
            put_byte(img[i]);
        end
        chk("gap_done",    32'(bus.load_done_o), 32'd1);
        chk("gap_cpu_rst", 32'(bus.cpu_rst_o), 32'd0);
        rd(1'b1, 32'h0, d); chk("gap_rd0", d, 32'h34011100);
        rd(1'b1, 32'h4, d); chk("gap_rd4", d, 32'h34020020);
        rd(1'b1, 32'h8, d); chk("gap_rd8_kept", d, 32'hC0DE0002);
        rd(1'b0, 32'h0, d);

        // 5. Restart mid-word; the byte offered with start must be dropped
        start_load();
        put_byte(8'h00);
        put_byte(8'h02);
        put_byte(8'h12);
        put_byte(8'h34);
        put_byte(8'h56);
        bus.load_start_i = 1'b1;
        bus.load_valid_i = 1'b1;
        bus.load_byte_i  = 8'h99;
        tick();
        bus.load_start_i = 1'b0;
        bus.load_valid_i = 1'b0;
        chk("rs_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
        chk("rs_done",    32'(bus.load_done_o), 32'd0);
        chk("rs_ready",   32'(bus.load_ready_o), 32'd1);
        put_byte(8'h00);
        put_byte(8'h01);
        put_word(32'hAABBCCDD);
        chk("rs_done2", 32'(bus.load_done_o), 32'd1);
        chk("rs_err2",  32'(bus.load_err_o), 32'd0);
        rd(1'b1, 32'h0, d); chk("rs_rd0", d, 32'hAABBCCDD);
        rd(1'b1, 32'h4, d); chk("rs_rd4", d, 32'h34020020);
        rd(1'b1, 32'h00001000, d); chk("rs_oor_rd", d, 32'h0);
        rd(1'b0, 32'h0, d);

        // 6. Async reset between edges, from DONE and from mid-DATA
        #2;
        rst = 1'b1;
        #1;
        chk("arst_done_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
        chk("arst_done_done",    32'(bus.load_done_o), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        start_load();
        put_byte(8'h00);
        put_byte(8'h02);
        put_byte(8'h01);
        put_byte(8'h02);
        chk("data_ready", 32'(bus.load_ready_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data_ready",   32'(bus.load_ready_o), 32'd0);
        chk("arst_data_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
        chk("arst_data_done",    32'(bus.load_done_o), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        rd(1'b1, 32'h0, d); chk("arst_ram_kept", d, 32'hAABBCCDD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
